// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, status flags and pipeline state.
// Used by decode, the legacy combinational ALU and alu_pipe.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: low N bits of a*b, one multiplier bit per cycle.
// done is asserted in the last iteration cycle; product is valid alongside it.
module alu_mul_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]  mcand, mplier, acc, acc_next;
  logic [CW-1:0] cnt;

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // The final iteration's sum is handed out directly so the caller can
  // register it on the same edge the counter reaches zero.
  assign done    = (cnt == CW'(1));
  assign product = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(N);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked registered ALU with a one-entry result buffer and optional
// iterative multiplier; one operation in flight at a time.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N      = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  alu_op_e      in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_zero,
  output logic         out_neg,
  output logic         out_carry,
  output logic         out_ovf,
  output logic         out_illegal
);

  localparam int SHW = $clog2(N);

  alu_state_e   state;
  alu_flags_t   flags_q, fl;
  logic [N-1:0] res;
  logic [N:0]   sum, diff;
  logic [SHW-1:0] shamt;
  logic         accept, mul_start, mul_done;
  logic [N-1:0] mul_product;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (in_op == ALU_MUL) && MUL_EN;

  assign sum   = {1'b0, in_a} + {1'b0, in_b};
  assign diff  = {1'b0, in_a} - {1'b0, in_b};
  assign shamt = in_b[SHW-1:0];

  // Single-cycle datapath; illegal codes leave res at zero so zero=1.
  always_comb begin
    res = '0;
    fl  = '0;
    case (in_op)
      ALU_ADD: begin
        res      = sum[N-1:0];
        fl.carry = sum[N];
        fl.ovf   = (in_a[N-1] == in_b[N-1]) && (sum[N-1] != in_a[N-1]);
      end
      ALU_SUB: begin
        res      = diff[N-1:0];
        fl.carry = !diff[N];
        fl.ovf   = (in_a[N-1] != in_b[N-1]) && (diff[N-1] != in_a[N-1]);
      end
      ALU_AND:  res = in_a & in_b;
      ALU_OR:   res = in_a | in_b;
      ALU_XOR:  res = in_a ^ in_b;
      ALU_SLT:  res = {{(N-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU: res = {{(N-1){1'b0}}, (in_a < in_b)};
      ALU_SLL:  res = in_a << shamt;
      ALU_SRL:  res = in_a >> shamt;
      ALU_SRA:  res = $unsigned($signed(in_a) >>> shamt);
      ALU_MUL:  fl.illegal = !MUL_EN;
      default:  fl.illegal = 1'b1;
    endcase
    fl.zero = (res == '0);
    fl.neg  = res[N-1];
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_nomul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // The buffer only loads on an accept (which implies it is draining or
  // empty) or at MUL completion (empty on entry), so a stalled result holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      flags_q    <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (mul_start) begin
              state <= ST_MUL;
            end else begin
              out_valid  <= 1'b1;
              out_result <= res;
              flags_q    <= fl;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state         <= ST_IDLE;
            out_valid     <= 1'b1;
            out_result    <= mul_product;
            flags_q       <= '0;
            flags_q.zero  <= (mul_product == '0);
            flags_q.neg   <= mul_product[N-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_zero    = flags_q.zero;
  assign out_neg     = flags_q.neg;
  assign out_carry   = flags_q.carry;
  assign out_ovf     = flags_q.ovf;
  assign out_illegal = flags_q.illegal;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Handshaked, registered, parametrised ALU: next generation of the combinational ALU.
- Adds shifts, unsigned compare and an iterative multiply.
- Adds status flags, an illegal-op indication and a one-entry output buffer with valid/ready on both sides.
- Sits between the issue stage and writeback; one operation in flight at a time.

Parameters:
N, 32, operand/result width; power of two, N >= 4
MUL_EN, 1, 1 = MUL supported (iterative, N cycles); 0 = MUL code treated as illegal
SHW, $clog2(N), shift-amount width (derived, not overridable)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- in_a  input  N  operand A
- in_b  input  N  operand B
- in_op  input  alu_op_e (4 bits)  operation
- out_valid  output  1  result buffer holds a result
- out_ready  input  1  consumer accepts result
- out_result  output  N  result
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[N-1]
- out_carry  output  1  ADD: carry-out; SUB: 1 when A >= B unsigned (no borrow); else 0
- out_ovf  output  1  signed overflow for ADD/SUB; else 0
- out_illegal  output  1  in_op not a legal code

Interface (already decided): one clock; reset is asynchronous and active-high; clock port is clk and reset port is rst.

Behaviour:
- Reset: state IDLE; out_valid=0; out_result=0; all flags 0; multiplier registers 0. Reset mid-operation abandons any MUL and drops a pending result; no partial result is ever presented.
- Accept rule: in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer happens when in_valid && in_ready. Accepting while the buffered result drains on the same edge is allowed, giving one op per cycle for single-cycle ops.
- Operations (alu_op_e, 4 bits):
  - ADD=0: A+B.
  - SUB=1: A-B.
  - AND=2, OR=3, XOR=4: bitwise.
  - SLT=5: result = {N-1 zeros, signed A<B}.
  - SLTU=6: result = {N-1 zeros, unsigned A<B}.
  - SLL=7, SRL=8, SRA=9: shift A by B[SHW-1:0]; SRA sign-fills.
  - MUL=10: low N bits of A*B, unsigned/signed-agnostic.
  - Codes 11-15, and MUL when MUL_EN=0: illegal.
- Single-cycle ops: operation accepted at edge k is registered at edge k; out_valid=1 from edge k until the consumer handshake. Latency 1 cycle.
- Illegal op: accepted normally with 1-cycle latency; result 0, out_zero=1, out_illegal=1, other flags 0.
- FSM:
  - IDLE -> MUL on accept of MUL when MUL_EN=1. Captures multiplicand, multiplier and accumulator=0, and sets counter to N.
  - MUL: each cycle, if multiplier[0] then accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter--.
  - MUL -> IDLE when counter reaches 0. The accumulator loads the output buffer on that edge; out_valid rises exactly N cycles after the accept edge.
  - in_ready=0 throughout MUL. The output buffer is guaranteed empty on entry to MUL.
- Output stability: while out_valid && !out_ready, out_result and all flags hold constant.
- Width rules:
  - ADD/SUB computed in N+1 bits for carry.
  - Overflow: ADD: (A[N-1]==B[N-1]) && (R[N-1]!=A[N-1]). SUB: (A[N-1]!=B[N-1]) && (R[N-1]!=A[N-1]).
  - out_carry and out_ovf are 0 for every non-ADD/SUB op, including MUL.
  - Shifts by 0 return A unchanged.
  - Operand bits above SHW in B are ignored for shifts.
- Inputs are ignored when in_ready=0. No X propagation from in_a/in_b/in_op when in_valid=0.

Decomposition:
- Package alu_pkg: alu_op_e enum (4-bit, codes above) and the flag struct (zero, neg, carry, ovf, illegal). Shared with decode and the existing ALU.
- Sub-module alu_mul_iter: shift-add multiplier with start/done and parameter N; instantiated only when MUL_EN=1, via a generate.
- The combinational single-cycle datapath stays inside alu_pipe.

Test Plan (N=8):
- ADD 0x7F+0x01 -> out_result=0x80, neg=1, ovf=1, carry=0, zero=0; out_valid one cycle after accept.
- SUB 0x05-0x05 -> 0x00, zero=1, carry=1. SLT 0x80,0x01 -> 0x01. SLTU 0x80,0x01 -> 0x00.
- Shifts with B=0x0B (amount 3): SLL 0x81 -> 0x08; SRL 0x80 -> 0x10; SRA 0x80 -> 0xF0. Shift by 0 returns A.
- MUL 0x0D*0x0B -> 0x8F.
  - out_valid exactly 8 cycles after accept; in_ready=0 for those cycles.
  - Repeat with MUL_EN=0 -> out_illegal=1, result 0.
- Backpressure: result pending with out_ready=0 and in_valid held -> in_ready=0, outputs stable 5 cycles. Raise out_ready -> next op accepted the same edge, and its result appears next cycle. Back-to-back ADDs sustain 1/cycle.
- Reset asserted 3 cycles into a MUL -> out_valid=0 and out_result=0 immediately (async). After deassert in_ready=1 and no stale result appears; op code 12 -> out_illegal=1, zero=1.
